// File: rtl/spi_txn_arbiter_pkg.sv
// Shared state type, owner index type and defaults for spi_txn_arbiter.
package spi_txn_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } arb_state_e;

    // Owner index sized for the largest supported requester count (8).
    localparam int MAX_REQ = 8;
    localparam int OWNER_W = $clog2(MAX_REQ);
    typedef logic [OWNER_W-1:0] owner_t;

    localparam int GAP_CYC_DEF = 2;

    function automatic owner_t next_owner(input owner_t cur, input int num_req);
        if (int'(cur) >= num_req - 1) begin
            return '0;
        end
        return cur + owner_t'(1);
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Client-side and engine-side signals around spi_txn_arbiter.
// timeout_err exists only when SPI_TXN_ARB_TIMEOUT_EN is defined.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      m_start;
    logic [DATA_W-1:0]         m_tx_data;
    logic                      m_busy;
    logic                      m_done;
    logic [DATA_W-1:0]         m_rx_data;
    logic [NUM_REQ-1:0]        cs_n;
    logic                      arb_busy;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
    logic                      timeout_err;
`endif

    modport master (
        input  req, req_data, m_busy, m_done, m_rx_data,
        output gnt, rsp_valid, rsp_data, m_start, m_tx_data, cs_n, arb_busy
`ifdef SPI_TXN_ARB_TIMEOUT_EN
        , output timeout_err
`endif
    );

    modport slave (
        output req, req_data, m_busy, m_done, m_rx_data,
        input  gnt, rsp_valid, rsp_data, m_start, m_tx_data, cs_n, arb_busy
`ifdef SPI_TXN_ARB_TIMEOUT_EN
        , input timeout_err
`endif
    );

endinterface

// File: rtl/spi_txn_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or above ptr, wrapping.
module rr_arbiter
    import spi_txn_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  owner_t             ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output owner_t             idx_o,
    output logic               any_o
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;
    int                   sum;

    // Rotating a doubled copy puts the ptr requester at bit 0.
    always_comb begin
        dbl   = {req_i, req_i} >> ptr_i;
        found = 1'b0;
        sum   = 0;
        idx_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && dbl[k]) begin
                found = 1'b1;
                sum   = int'(ptr_i) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                idx_o = owner_t'(sum);
            end
        end
        any_o = found;
        gnt_o = found ? (ONE_HOT0 << idx_o) : '0;
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI shift engine among NUM_REQ clients.
// Define SPI_TXN_ARB_TIMEOUT_EN to add the WAIT timeout and timeout_err pulse.
//
// state | meaning
// IDLE  | arbitrate when any req is high and the engine is not busy
// START | pulse m_start to the engine
// WAIT  | hold owner's chip select until m_done (or timeout)
// GAP   | all chip selects high for GAP_CYC cycles
module spi_txn_arbiter
    import spi_txn_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int GAP_CYC = GAP_CYC_DEF
`ifdef SPI_TXN_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 255
`endif
) (
    input logic               clk,
    input logic               rst,
    spi_txn_arbiter_if.master bus
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [NUM_REQ-1:0] CS_IDLE  = '1;
    localparam logic [3:0]         GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    arb_state_e         state_q;
    owner_t             ptr_q;
    owner_t             owner_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [NUM_REQ-1:0] cs_n_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [DATA_W-1:0]  m_tx_data_q;
    logic               m_start_q;
    logic [3:0]         gap_q;

    logic [NUM_REQ-1:0] arb_gnt;
    owner_t             arb_idx;
    logic               arb_any;
    logic [DATA_W-1:0]  sel_data;
    logic               wait_end;
    logic [DATA_W-1:0]  wait_rx;

`ifdef SPI_TXN_ARB_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_q;
    logic            timeout_err_q;
    logic            timeout_hit;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A timeout ends WAIT like a completion, but with a zero response byte.
    always_comb begin
        wait_end = bus.m_done;
        wait_rx  = bus.m_rx_data;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
        if (!bus.m_done && (to_q == '0)) begin
            wait_end    = 1'b1;
            wait_rx     = '0;
            timeout_hit = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            m_start_q   <= 1'b0;
            m_tx_data_q <= '0;
            cs_n_q      <= CS_IDLE;
            gap_q       <= '0;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
            to_q          <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            m_start_q   <= 1'b0;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (arb_any && !bus.m_busy) begin
                        gnt_q       <= arb_gnt;
                        owner_q     <= arb_idx;
                        m_tx_data_q <= sel_data;
                        cs_n_q      <= ~arb_gnt;
                        state_q     <= START;
                    end
                end
                START: begin
                    m_start_q <= 1'b1;
                    state_q   <= WAIT;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
                    to_q      <= TO_LOAD;
`endif
                end
                WAIT: begin
                    if (wait_end) begin
                        rsp_data_q  <= wait_rx;
                        rsp_valid_q <= ONE_HOT0 << owner_q;
                        cs_n_q      <= CS_IDLE;
                        ptr_q       <= next_owner(owner_q, NUM_REQ);
                        gap_q       <= GAP_LOAD;
                        state_q     <= (GAP_CYC > 0) ? GAP : IDLE;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
                        timeout_err_q <= timeout_hit;
                    end else begin
                        to_q <= to_q - 1'b1;
`endif
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.m_start   = m_start_q;
    assign bus.m_tx_data = m_tx_data_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.arb_busy  = (state_q != IDLE);
`ifdef SPI_TXN_ARB_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: directed scenarios plus random traffic against a
// cycle-timed transaction model of the arbiter.
module tb_spi_txn_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int TO  = 16;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic          eng_busy, eng_done, force_busy, stray_done, eng_hang, eng_rx_fix_en, keep_req;
    int            eng_lat_fix;
    logic [DW-1:0] eng_rx_fix;

    spi_txn_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    spi_txn_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .GAP_CYC (GAP)
`ifdef SPI_TXN_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC (TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.m_busy = eng_busy | force_busy;
    assign bus.m_done = eng_done | stray_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model and event log ----------------
    bit            armed = 0, active = 0, start_pending = 0;
    int            free_at = 0, wait_start = 0, m_ptr = 0, m_owner = 0;
    logic [N-1:0]  e_gnt, e_rsp, e_cs;
    logic          e_start, e_busy, e_to;
    logic [DW-1:0] e_rsp_data, e_tx;

    int            gq[$];
    int            sq[$];
    int            last_gnt_cyc[N];
    int            rsp_cnt = 0, last_rsp_cyc = 0, start_cnt = 0, last_start_cyc = 0;
    int            to_cnt = 0, to_cyc = 0;
    logic [N-1:0]  last_rsp_vec;
    logic [DW-1:0] last_rsp_data, last_start_tx;

    always @(negedge clk) begin
        logic [N-1:0]  n_gnt, n_rsp;
        logic          n_start, n_to, fin;
        logic [DW-1:0] fin_data;
        int            w, j;

        if (armed) begin
            check_eq("gnt", 32'(bus.gnt), 32'(e_gnt));
            check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
            check_eq("rsp_data", 32'(bus.rsp_data), 32'(e_rsp_data));
            check_eq("m_start", 32'(bus.m_start), 32'(e_start));
            check_eq("m_tx_data", 32'(bus.m_tx_data), 32'(e_tx));
            check_eq("cs_n", 32'(bus.cs_n), 32'(e_cs));
            check_eq("arb_busy", 32'(bus.arb_busy), 32'(e_busy));
            check_eq("cs_one_low", 32'($countones(~bus.cs_n) <= 1), 32'd1);
`ifdef SPI_TXN_ARB_TIMEOUT_EN
            check_eq("timeout_err", 32'(bus.timeout_err), 32'(e_to));
            if (bus.timeout_err === 1'b1) begin to_cnt++; to_cyc = cyc; end
`endif
        end

        for (int i = 0; i < N; i++) begin
            if (bus.gnt[i] === 1'b1) begin gq.push_back(i); last_gnt_cyc[i] = cyc; end
        end
        if (bus.m_start === 1'b1) begin
            sq.push_back(cyc); start_cnt++; last_start_cyc = cyc; last_start_tx = bus.m_tx_data;
        end
        if (bus.rsp_valid !== '0) begin
            rsp_cnt++; last_rsp_cyc = cyc; last_rsp_vec = bus.rsp_valid; last_rsp_data = bus.rsp_data;
        end

        n_gnt = '0; n_rsp = '0; n_start = 1'b0; n_to = 1'b0; fin = 1'b0; fin_data = '0;
        if (rst) begin
            active = 0; start_pending = 0; free_at = cyc + 1;
            m_ptr = 0; m_owner = 0; e_cs = '1; e_rsp_data = '0; e_tx = '0; armed = 1;
        end else if (start_pending) begin
            n_start = 1'b1; start_pending = 0; wait_start = cyc + 1;
        end else if (active) begin
            if (bus.m_done) begin
                fin = 1'b1; fin_data = bus.m_rx_data;
`ifdef SPI_TXN_ARB_TIMEOUT_EN
            end else if (cyc == wait_start + TO - 1) begin
                fin = 1'b1; fin_data = '0; n_to = 1'b1;
`endif
            end
            if (fin) begin
                n_rsp = N'(1) << m_owner; e_rsp_data = fin_data; e_cs = '1;
                m_ptr = (m_owner + 1) % N; active = 0; free_at = cyc + 1 + GAP;
            end
        end else if (cyc >= free_at && bus.req != '0 && !bus.m_busy) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (w < 0 && bus.req[j]) w = j;
            end
            n_gnt = N'(1) << w; m_owner = w; e_tx = bus.req_data[w*DW +: DW];
            e_cs = ~n_gnt; active = 1; start_pending = 1;
        end
        e_gnt = n_gnt; e_rsp = n_rsp; e_start = n_start; e_to = n_to;
        e_busy = active || start_pending || (cyc + 1 < free_at);
    end

    // ---------------- SPI engine stand-in ----------------
    initial begin
        int lat;
        eng_busy = 1'b0; eng_done = 1'b0; bus.m_rx_data = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.m_start === 1'b1 && !eng_hang) begin
                eng_busy = 1'b1;
                lat = (eng_lat_fix > 0) ? eng_lat_fix : int'($urandom_range(1, 6));
                repeat (lat) @(posedge clk);
                #1 eng_done = 1'b1;
                bus.m_rx_data = eng_rx_fix_en ? eng_rx_fix : DW'($urandom);
                @(posedge clk); #1 eng_done = 1'b0; eng_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
        if (!keep_req) bus.req = bus.req & ~bus.gnt;
    endtask

    task automatic wait_rsp(input string tag, input int base, input int budget);
        int t = 0;
        while (rsp_cnt <= base && t < budget) begin step(); t++; end
        check_eq(tag, 32'(rsp_cnt > base), 32'd1);
    endtask

    task automatic wait_start_evt(input string tag, input int base, input int budget);
        int t = 0;
        while (start_cnt <= base && t < budget) begin step(); t++; end
        check_eq(tag, 32'(start_cnt > base), 32'd1);
    endtask

    task automatic wait_gnts(input string tag, input int target, input int budget);
        int t = 0;
        while (gq.size() < target && t < budget) begin step(); t++; end
        check_eq(tag, 32'(gq.size() >= target), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fall;
        rst = 1'b1; bus.req = '0; bus.req_data = '0;
        force_busy = 0; stray_done = 0; eng_hang = 0; keep_req = 0;
        eng_lat_fix = 0; eng_rx_fix_en = 0; eng_rx_fix = '0;
        repeat (3) step();
        rst = 1'b0;

        // Single request with fixed loopback byte
        gq.delete();
        eng_lat_fix = 3; eng_rx_fix_en = 1; eng_rx_fix = 8'h3C;
        bus.req_data[2*DW +: DW] = 8'hA5; bus.req = 4'b0100;
        base = rsp_cnt;
        wait_rsp("single_rsp_seen", base, 60);
        check_eq("single_gnt_idx", 32'(gq[0]), 32'd2);
        check_eq("single_tx", 32'(last_start_tx), 32'hA5);
        check_eq("single_rsp_vec", 32'(last_rsp_vec), 32'b0100);
        check_eq("single_rsp_data", 32'(last_rsp_data), 32'h3C);
        check_eq("single_start_lat", 32'(last_start_cyc - last_gnt_cyc[2]), 32'd1);
        repeat (6) step();

        // All four requesting continuously from reset
        rst = 1'b1; keep_req = 1; eng_lat_fix = 2; eng_rx_fix_en = 0;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'($urandom);
        bus.req = '1;
        step(); step();
        gq.delete(); sq.delete();
        rst = 1'b0;
        wait_gnts("rot_gnts_seen", 5, 200);
        for (int i = 0; i < 5; i++) check_eq("rot_order", 32'(gq[i]), 32'(i % N));
        for (int i = 1; i < sq.size(); i++)
            check_eq("start_spacing_ok", 32'((sq[i] - sq[i-1]) >= GAP + 4), 32'd1);
        keep_req = 0; bus.req = '0;
        repeat (30) step();

        // Request arriving while owner 1 is in WAIT
        gq.delete(); eng_lat_fix = 6; eng_rx_fix_en = 1; eng_rx_fix = 8'h5A;
        bus.req = 4'b0010; base = start_cnt;
        wait_start_evt("wait_start_seen", base, 40);
        step(); step();
        bus.req[3] = 1'b1;
        wait_gnts("wait_gnt3_seen", 2, 60);
        check_eq("wait_order0", 32'(gq[0]), 32'd1);
        check_eq("wait_order1", 32'(gq[1]), 32'd3);
        check_eq("wait_rsp1_vec", 32'(last_rsp_vec), 32'b0010);
        check_eq("wait_rsp1_data", 32'(last_rsp_data), 32'h5A);
        check_eq("wait_gnt3_after_gap", 32'(last_gnt_cyc[3] - last_rsp_cyc), 32'(GAP + 1));
        repeat (30) step();

        // Engine busy holds the arbiter in IDLE
        gq.delete(); force_busy = 1; bus.req = 4'b0001;
        repeat (10) step();
        check_eq("busy_no_gnt", 32'(gq.size()), 32'd0);
        force_busy = 0; fall = cyc;
        wait_gnts("busy_gnt_seen", 1, 10);
        check_eq("busy_gnt_timing", 32'(last_gnt_cyc[0] - fall), 32'd1);
        repeat (30) step();

        // Reset pulsed during WAIT, then a stray done
        eng_lat_fix = 8; bus.req = 4'b0100; base = start_cnt;
        wait_start_evt("rst_start_seen", base, 40);
        step();
        rst = 1'b1; step();
        check_eq("rst_cs_n", 32'(bus.cs_n), 32'hF);
        check_eq("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
        rst = 1'b0; base = rsp_cnt;
        step(); step();
        stray_done = 1'b1; step(); stray_done = 1'b0;
        repeat (12) step();
        check_eq("rst_no_rsp", 32'(rsp_cnt - base), 32'd0);
        repeat (10) step();

`ifdef SPI_TXN_ARB_TIMEOUT_EN
        // Engine never answers
        eng_hang = 1; eng_lat_fix = 0; eng_rx_fix_en = 0;
        bus.req = 4'b0010; base = to_cnt;
        begin
            int t = 0;
            while (to_cnt <= base && t < 80) begin step(); t++; end
        end
        check_eq("to_seen", 32'(to_cnt > base), 32'd1);
        check_eq("to_latency", 32'(to_cyc - last_start_cyc), 32'(TO));
        check_eq("to_rsp_vec", 32'(last_rsp_vec), 32'b0010);
        check_eq("to_rsp_data", 32'(last_rsp_data), 32'h00);
        eng_hang = 0; repeat (4) step();
        bus.req = 4'b0100; base = rsp_cnt;
        wait_rsp("to_next_rsp_seen", base, 60);
        check_eq("to_next_rsp_vec", 32'(last_rsp_vec), 32'b0100);
        repeat (10) step();
`endif

        // Random traffic
        eng_lat_fix = 0; eng_rx_fix_en = 0;
        for (int t = 0; t < 2500; t++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
                    bus.req[i] = 1'b1; bus.req_data[i*DW +: DW] = DW'($urandom);
                end else if (bus.req[i] && $urandom_range(0, 63) == 0) begin
                    bus.req[i] = 1'b0;
                end
                if ($urandom_range(0, 15) == 0) bus.req_data[i*DW +: DW] = DW'($urandom);
            end
            force_busy = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 599) == 0);
        end
        rst = 1'b0; force_busy = 0; bus.req = '0;
        repeat (40) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
